// File: rtl/dma_priority_arbiter.sv
// ============================================================================
// Module   : dma_priority_arbiter
// Brief    : DMA priority stage: request qualification, fixed/rotating winner
//            selection, HRQ/HLDA handshake, DACK drive and grant hand-off.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dma_priority_arbiter #(
    parameter int         NUM_CH        = 4,
    parameter logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_dreq,
    input  logic              i_hlda,
    input  logic              i_controller_disable,
    input  logic              i_priority_type,
    input  logic              i_dreq_sense,
    input  logic              i_dack_sense,
    input  logic [NUM_CH-1:0] i_mask_reg,
    input  logic              i_service_done,
    output logic              o_hrq,
    output logic [NUM_CH-1:0] o_dack,
    output logic              o_grant_valid,
    output logic [1:0]        o_grant_channel,
    output logic              o_start_cycle,
    output logic [7:0]        o_priority_order
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_HLDA = 2'd1,
        S_GRANT     = 2'd2,
        S_RELEASE   = 2'd3
    } state_t;

    state_t            r_state;
    logic [NUM_CH-1:0] r_req_q;
    logic              r_hrq;
    logic              r_grant_valid;
    logic              r_start_cycle;
    logic [1:0]        r_grant_channel;
    logic [NUM_CH-1:0] r_dack;
    logic [7:0]        r_priority_order;

    state_t            w_next_state;
    logic [NUM_CH-1:0] w_next_req;
    logic              w_next_hrq;
    logic              w_next_grant_valid;
    logic              w_next_start_cycle;
    logic [1:0]        w_next_grant_channel;
    logic [NUM_CH-1:0] w_next_dack;
    logic [7:0]        w_next_order;

    logic [1:0]        w_field [4];
    logic              w_win_valid;
    logic [1:0]        w_win_ch;
    logic [1:0]        w_pos;
    logic [7:0]        w_rot_order;
    logic [NUM_CH-1:0] w_onehot;
    logic [NUM_CH-1:0] w_dack_idle;

    assign w_next_req  = (i_dreq ^ {NUM_CH{i_dreq_sense}}) & ~i_mask_reg;
    assign w_onehot    = {{(NUM_CH-1){1'b0}}, 1'b1} << r_grant_channel;
    assign w_dack_idle = {NUM_CH{i_dack_sense}};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_field[i] = r_priority_order[2*i +: 2];
        end
    end

    // Scan lowest priority first so the highest-priority hit is the last write.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_ch    = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_req_q[w_field[i]]) begin
                w_win_valid = 1'b1;
                w_win_ch    = w_field[i];
            end
        end
    end

    // Rotate so the field after the serviced channel becomes the new head.
    always_comb begin
        w_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (w_field[i] == r_grant_channel) begin
                w_pos = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            w_rot_order[2*i +: 2] = w_field[2'(w_pos + 2'(i) + 2'd1)];
        end
    end

    always_comb begin
        w_next_state         = r_state;
        w_next_hrq           = r_hrq;
        w_next_grant_valid   = r_grant_valid;
        w_next_start_cycle   = 1'b0;
        w_next_grant_channel = r_grant_channel;
        w_next_dack          = w_dack_idle;
        w_next_order         = r_priority_order;
        case (r_state)
            S_IDLE: begin
                if (!i_priority_type) begin
                    w_next_order = DEFAULT_ORDER;
                end
                if (w_win_valid && !i_controller_disable) begin
                    w_next_grant_channel = w_win_ch;
                    w_next_hrq           = 1'b1;
                    w_next_state         = S_WAIT_HLDA;
                end
            end
            S_WAIT_HLDA: begin
                if (!r_req_q[r_grant_channel]) begin
                    w_next_hrq   = 1'b0;
                    w_next_state = S_IDLE;
                end else if (i_hlda) begin
                    w_next_state       = S_GRANT;
                    w_next_grant_valid = 1'b1;
                    w_next_start_cycle = 1'b1;
                    w_next_dack        = w_onehot ^ w_dack_idle;
                end
            end
            S_GRANT: begin
                // A done pulse wins over a simultaneous HLDA drop.
                if (i_service_done) begin
                    w_next_state       = S_RELEASE;
                    w_next_grant_valid = 1'b0;
                    w_next_hrq         = 1'b0;
                end else if (!i_hlda) begin
                    w_next_state       = S_IDLE;
                    w_next_grant_valid = 1'b0;
                    w_next_hrq         = 1'b0;
                end else begin
                    w_next_dack = r_dack;
                end
            end
            S_RELEASE: begin
                if (i_priority_type) begin
                    w_next_order = w_rot_order;
                end
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_IDLE;
            r_req_q          <= '0;
            r_hrq            <= 1'b0;
            r_grant_valid    <= 1'b0;
            r_start_cycle    <= 1'b0;
            r_grant_channel  <= 2'd0;
            r_dack           <= '0;
            r_priority_order <= DEFAULT_ORDER;
        end else begin
            r_state          <= w_next_state;
            r_req_q          <= w_next_req;
            r_hrq            <= w_next_hrq;
            r_grant_valid    <= w_next_grant_valid;
            r_start_cycle    <= w_next_start_cycle;
            r_grant_channel  <= w_next_grant_channel;
            r_dack           <= w_next_dack;
            r_priority_order <= w_next_order;
        end
    end

    assign o_hrq            = r_hrq;
    assign o_dack           = r_dack;
    assign o_grant_valid    = r_grant_valid;
    assign o_grant_channel  = r_grant_channel;
    assign o_start_cycle    = r_start_cycle;
    assign o_priority_order = r_priority_order;

endmodule

`default_nettype wire
